// File: rtl/delta_energy_pipe.sv
// Streaming Ising delta-energy accumulator: per-column J dot products against row spins,
// summed per beat, accumulated per transaction and held as a handshaked result.
module delta_energy_pipe #(
    parameter int VECTOR_SIZE = 256,
    parameter int COL_PER_CC  = 4,
    parameter int DATA_WIDTH  = 4,
    parameter int J_SIGNED    = 0,
    parameter int PIPE_EN     = 0,
    parameter int ACCUM_WIDTH = DATA_WIDTH + $clog2(VECTOR_SIZE*VECTOR_SIZE) + 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 clear,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic                                                 in_last,
    input  logic [COL_PER_CC-1:0]                                in_col_en,
    input  logic [COL_PER_CC-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] j_cols,
    input  logic [VECTOR_SIZE-1:0][1:0]                          sigma_r,
    input  logic [COL_PER_CC-1:0]                                sigma_c,
    output logic                                                 res_valid,
    input  logic                                                 res_ready,
    output logic [ACCUM_WIDTH-1:0]                               res_data,
    output logic                                                 res_ovf
);
    localparam int DOT_W  = DATA_WIDTH + 2 + $clog2(VECTOR_SIZE);
    localparam int BEAT_W = DOT_W + $clog2(COL_PER_CC) + 1;
    localparam int MSB    = ACCUM_WIDTH - 1;

    typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_HOLD} state_t;

    function automatic logic signed [DOT_W-1:0] col_dot(
        input logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] jc,
        input logic [VECTOR_SIZE-1:0][1:0]            sr,
        input logic                                   sc
    );
        logic signed [DOT_W-1:0] sum;
        logic signed [DOT_W-1:0] jv;
        sum = '0;
        for (int k = 0; k < VECTOR_SIZE; k++) begin
            jv = (J_SIGNED != 0) ? DOT_W'($signed(jc[k])) : DOT_W'($signed({1'b0, jc[k]}));
            if (sr[k] == 2'b01)      sum = sum + jv;
            else if (sr[k] == 2'b11) sum = sum - jv;
        end
        return sc ? sum : -sum;
    endfunction

    state_t state_q, state_d;
    logic   accept;

    logic                                                 s0_valid_q, s0_valid_d;
    logic                                                 s0_last_q, s0_last_d;
    logic [COL_PER_CC-1:0]                                s0_col_en_q, s0_col_en_d;
    logic [COL_PER_CC-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] s0_j_q, s0_j_d;
    logic [VECTOR_SIZE-1:0][1:0]                          s0_sr_q, s0_sr_d;
    logic [COL_PER_CC-1:0]                                s0_sc_q, s0_sc_d;

    logic signed [DOT_W-1:0]       dot_c [COL_PER_CC];
    logic signed [BEAT_W-1:0]      beat_sum;
    logic                          add_valid, add_last;
    logic signed [ACCUM_WIDTH-1:0] add_beat;

    logic signed [ACCUM_WIDTH-1:0] acc_q, acc_d, acc_sum;
    logic                          ovf_acc_q, ovf_acc_d, add_ovf;
    logic                          res_valid_q, res_valid_d;
    logic [ACCUM_WIDTH-1:0]        res_data_q, res_data_d;
    logic                          res_ovf_q, res_ovf_d;

    assign in_ready = (state_q == ST_ACC);
    assign accept   = in_valid && in_ready && !clear;

    always_comb begin
        s0_valid_d  = accept;
        s0_last_d   = s0_last_q;
        s0_col_en_d = s0_col_en_q;
        s0_j_d      = s0_j_q;
        s0_sr_d     = s0_sr_q;
        s0_sc_d     = s0_sc_q;
        if (accept) begin
            s0_last_d   = in_last;
            s0_col_en_d = in_col_en;
            s0_j_d      = j_cols;
            s0_sr_d     = sigma_r;
            s0_sc_d     = sigma_c;
        end
    end

    for (genvar gi = 0; gi < COL_PER_CC; gi++) begin : g_col
        assign dot_c[gi] = s0_col_en_q[gi] ? col_dot(s0_j_q[gi], s0_sr_q, s0_sc_q[gi]) : '0;
    end

    always_comb begin
        beat_sum = '0;
        for (int c = 0; c < COL_PER_CC; c++) begin
            beat_sum = beat_sum + BEAT_W'(dot_c[c]);
        end
    end

    if (PIPE_EN != 0) begin : g_pipe
        logic                          p_valid_q, p_valid_d;
        logic                          p_last_q, p_last_d;
        logic signed [ACCUM_WIDTH-1:0] p_sum_q, p_sum_d;

        always_comb begin
            p_valid_d = s0_valid_q && !clear;
            p_last_d  = s0_valid_q ? s0_last_q : p_last_q;
            p_sum_d   = s0_valid_q ? ACCUM_WIDTH'(beat_sum) : p_sum_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p_valid_q <= 1'b0;
                p_last_q  <= 1'b0;
                p_sum_q   <= '0;
            end else begin
                p_valid_q <= p_valid_d;
                p_last_q  <= p_last_d;
                p_sum_q   <= p_sum_d;
            end
        end

        assign add_valid = p_valid_q;
        assign add_last  = p_last_q;
        assign add_beat  = p_sum_q;
    end else begin : g_nopipe
        assign add_valid = s0_valid_q;
        assign add_last  = s0_last_q;
        assign add_beat  = ACCUM_WIDTH'(beat_sum);
    end

    // Overflow: operands agree in sign but the wrapped sum does not.
    assign acc_sum = acc_q + add_beat;
    assign add_ovf = (acc_q[MSB] == add_beat[MSB]) && (acc_sum[MSB] != acc_q[MSB]);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;
        if (clear) begin
            state_d     = ST_ACC;
            acc_d       = '0;
            ovf_acc_d   = 1'b0;
            res_valid_d = 1'b0;
            res_data_d  = '0;
            res_ovf_d   = 1'b0;
        end else begin
            if (add_valid) begin
                if (add_last) begin
                    res_data_d  = acc_sum;
                    res_ovf_d   = ovf_acc_q | add_ovf;
                    res_valid_d = 1'b1;
                    acc_d       = '0;
                    ovf_acc_d   = 1'b0;
                end else begin
                    acc_d     = acc_sum;
                    ovf_acc_d = ovf_acc_q | add_ovf;
                end
            end
            case (state_q)
                ST_ACC:   if (accept && in_last) state_d = ST_DRAIN;
                ST_DRAIN: if (add_valid && add_last) state_d = ST_HOLD;
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = ST_ACC;
                    end
                end
                default:  state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            s0_valid_q  <= 1'b0;
            s0_last_q   <= 1'b0;
            s0_col_en_q <= '0;
            s0_j_q      <= '0;
            s0_sr_q     <= '0;
            s0_sc_q     <= '0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s0_valid_q  <= s0_valid_d;
            s0_last_q   <= s0_last_d;
            s0_col_en_q <= s0_col_en_d;
            s0_j_q      <= s0_j_d;
            s0_sr_q     <= s0_sr_d;
            s0_sc_q     <= s0_sc_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_ovf   = res_ovf_q;
endmodule

// File: tb/tb_delta_energy_pipe.sv
// Bench for delta_energy_pipe: four instances covering PIPE_EN x J_SIGNED (signed ones with an
// 8-bit accumulator), directed scenarios plus random transactions against an arithmetic model.
module tb_delta_energy_pipe;
    localparam int VS = 8;
    localparam int CPC = 2;
    localparam int DW = 4;
    localparam int NU = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n [NU];
    logic clear [NU];
    logic in_valid [NU];
    logic res_ready [NU];
    logic in_last;
    logic [CPC-1:0] in_col_en;
    logic [CPC-1:0][VS-1:0][DW-1:0] j_cols;
    logic [VS-1:0][1:0] sigma_r;
    logic [CPC-1:0] sigma_c;

    logic in_ready_w [NU];
    logic res_valid_w [NU];
    logic res_ovf_w [NU];
    int   res_data_w [NU];

    int checks = 0;
    int errors = 0;
    int m_acc = 0;
    int m_ovf = 0;

    for (genvar gi = 0; gi < NU; gi++) begin : g_dut
        localparam int PE = gi % 2;
        localparam int JS = gi / 2;
        localparam int AW = (JS == 1) ? 8 : (DW + $clog2(VS*VS) + 1);
        logic [AW-1:0] rd;
        delta_energy_pipe #(
            .VECTOR_SIZE(VS), .COL_PER_CC(CPC), .DATA_WIDTH(DW),
            .J_SIGNED(JS), .PIPE_EN(PE), .ACCUM_WIDTH(AW)
        ) u_dut (
            .clk(clk), .rst_n(rst_n[gi]), .clear(clear[gi]),
            .in_valid(in_valid[gi]), .in_ready(in_ready_w[gi]), .in_last(in_last),
            .in_col_en(in_col_en), .j_cols(j_cols), .sigma_r(sigma_r), .sigma_c(sigma_c),
            .res_valid(res_valid_w[gi]), .res_ready(res_ready[gi]),
            .res_data(rd), .res_ovf(res_ovf_w[gi])
        );
        assign res_data_w[gi] = int'($signed(rd));
    end

    function automatic int pe_of(input int u); return u % 2; endfunction
    function automatic int js_of(input int u); return u / 2; endfunction
    function automatic int aw_of(input int u); return (u / 2 == 1) ? 8 : 11; endfunction

    function automatic int wrap(input int x, input int aw);
        int m;
        int h;
        m = 1 << aw;
        h = m / 2;
        return ((x + h) % m + m) % m - h;
    endfunction

    // Energy contribution of the beat currently on the input bus.
    function automatic int beat_val(input int js);
        int s;
        int jv;
        int sr;
        int sc;
        logic [DW-1:0] jb;
        s = 0;
        for (int c = 0; c < CPC; c++) begin
            if (in_col_en[c]) begin
                sc = sigma_c[c] ? 1 : -1;
                for (int k = 0; k < VS; k++) begin
                    jb = j_cols[c][k];
                    jv = (js != 0) ? int'($signed(jb)) : int'(jb);
                    sr = (sigma_r[k] == 2'b01) ? 1 : ((sigma_r[k] == 2'b11) ? -1 : 0);
                    s += jv * sr * sc;
                end
            end
        end
        return s;
    endfunction

    task automatic chk(input string tag, input int u, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d expected %0d", tag, u, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [DW-1:0] jv, input logic [15:0] sr,
                            input logic [1:0] sc, input logic [1:0] en);
        for (int c = 0; c < CPC; c++)
            for (int k = 0; k < VS; k++) j_cols[c][k] = jv;
        sigma_r = sr;
        sigma_c = sc;
        in_col_en = en;
    endtask

    task automatic rand_beat();
        for (int c = 0; c < CPC; c++)
            for (int k = 0; k < VS; k++) j_cols[c][k] = 4'($urandom);
        sigma_r = 16'($urandom);
        sigma_c = 2'($urandom);
        in_col_en = 2'($urandom);
    endtask

    task automatic send_beat(input int u, input logic last);
        int aw;
        int h;
        int t;
        aw = aw_of(u);
        h = 1 << (aw - 1);
        in_last = last;
        in_valid[u] = 1'b1;
        chk("in_ready", u, in_ready_w[u], 1);
        t = m_acc + wrap(beat_val(js_of(u)), aw);
        if (t > h - 1 || t < -h) m_ovf = 1;
        m_acc = wrap(t, aw);
        tick();
        in_valid[u] = 1'b0;
    endtask

    task automatic finish_txn(input int u, input int hold, input int has_spec,
                              input int sx, input int sov);
        for (int i = 0; i <= pe_of(u); i++) begin
            chk("res_latency", u, res_valid_w[u], 0);
            chk("drain_ready", u, in_ready_w[u], 0);
            tick();
        end
        chk("res_valid", u, res_valid_w[u], 1);
        chk("res_data", u, res_data_w[u], m_acc);
        chk("res_ovf", u, res_ovf_w[u], m_ovf);
        if (has_spec != 0) begin
            chk("spec_data", u, res_data_w[u], sx);
            chk("spec_ovf", u, res_ovf_w[u], sov);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid[u] = 1'b1;
            tick();
            chk("hold_valid", u, res_valid_w[u], 1);
            chk("hold_data", u, res_data_w[u], m_acc);
            chk("hold_ready", u, in_ready_w[u], 0);
        end
        in_valid[u] = 1'b0;
        res_ready[u] = 1'b1;
        tick();
        res_ready[u] = 1'b0;
        chk("release_valid", u, res_valid_w[u], 0);
        chk("release_ready", u, in_ready_w[u], 1);
        m_acc = 0;
        m_ovf = 0;
    endtask

    initial begin
        for (int u = 0; u < NU; u++) begin
            rst_n[u] = 1'b0;
            clear[u] = 1'b0;
            in_valid[u] = 1'b0;
            res_ready[u] = 1'b0;
        end
        in_last = 1'b0;
        set_beat(4'd0, 16'h0, 2'b00, 2'b00);
        tick();

        for (int u = 0; u < NU; u++) begin
            m_acc = 0;
            m_ovf = 0;
            repeat (2) tick();
            chk("rst_ready", u, in_ready_w[u], 1);
            chk("rst_valid", u, res_valid_w[u], 0);
            rst_n[u] = 1'b1;
            for (int i = 0; i < 20; i++) begin
                tick();
                chk("idle_ready", u, in_ready_w[u], 1);
                chk("idle_valid", u, res_valid_w[u], 0);
                chk("idle_data", u, res_data_w[u], 0);
                chk("idle_ovf", u, res_ovf_w[u], 0);
            end

            set_beat(4'd3, 16'h5555, 2'b11, 2'b11);
            send_beat(u, 1'b1);
            finish_txn(u, 0, 1, 48, 0);
            set_beat(4'd3, 16'h5555, 2'b10, 2'b11);
            send_beat(u, 1'b1);
            finish_txn(u, 0, 1, 0, 0);

            set_beat(4'd5, 16'h0055, 2'b11, 2'b01);
            send_beat(u, 1'b0);
            set_beat(4'd2, 16'hFFFF, 2'b11, 2'b11);
            send_beat(u, 1'b1);
            finish_txn(u, 0, 1, -12, 0);

            set_beat(4'd3, 16'h5555, 2'b11, 2'b11);
            send_beat(u, 1'b1);
            finish_txn(u, 5, 1, 48, 0);
            send_beat(u, 1'b1);
            finish_txn(u, 0, 1, 48, 0);

            set_beat(4'd7, 16'h5555, 2'b11, 2'b11);
            send_beat(u, 1'b0);
            send_beat(u, 1'b1);
            finish_txn(u, 0, js_of(u), -32, 1);
            set_beat(4'hF, 16'h5555, 2'b11, 2'b01);
            send_beat(u, 1'b1);
            finish_txn(u, 0, js_of(u), -8, 0);

            rand_beat();
            send_beat(u, 1'b0);
            rand_beat();
            send_beat(u, 1'b0);
            rand_beat();
            in_last = 1'b1;
            in_valid[u] = 1'b1;
            clear[u] = 1'b1;
            tick();
            clear[u] = 1'b0;
            in_valid[u] = 1'b0;
            m_acc = 0;
            m_ovf = 0;
            chk("clear_ready", u, in_ready_w[u], 1);
            chk("clear_valid", u, res_valid_w[u], 0);
            repeat (2) tick();
            chk("clear_settled", u, res_valid_w[u], 0);
            set_beat(4'd3, 16'h5555, 2'b11, 2'b11);
            send_beat(u, 1'b1);
            finish_txn(u, 0, 1, 48, 0);

            send_beat(u, 1'b1);
            repeat (1 + pe_of(u)) tick();
            chk("hold_before_rst", u, res_valid_w[u], 1);
            rst_n[u] = 1'b0;
            #1;
            chk("async_rst_valid", u, res_valid_w[u], 0);
            chk("async_rst_data", u, res_data_w[u], 0);
            chk("async_rst_ready", u, in_ready_w[u], 1);
            #2;
            rst_n[u] = 1'b1;
            m_acc = 0;
            m_ovf = 0;
            tick();

            for (int t = 0; t < 25; t++) begin
                int nb;
                nb = $urandom_range(1, 4);
                for (int b = 0; b < nb; b++) begin
                    rand_beat();
                    send_beat(u, (b == nb - 1));
                    if (b < nb - 1) repeat ($urandom_range(0, 2)) tick();
                end
                finish_txn(u, $urandom_range(0, 3), 0, 0, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/delta_energy_pipe.md
# delta_energy_pipe

Parametrised, pipelined successor to the column-streaming compute unit. It accumulates the Ising energy-difference partial sum Σ_c Σ_k J[c][k]·σr[k]·σc[c] over a stream of column beats. Compared with the earlier unit it adds:
- a valid/ready input handshake;
- per-column enables;
- a selectable signed or unsigned J;
- an optional internal pipeline register;
- a held result with valid/ready handshake and a sticky overflow flag.

It sits between the J-column fetch/spin-flip scheduler and the energy-acceptance logic.

## Interface
- VECTOR_SIZE, 256, elements per J column (≥2)
- COL_PER_CC, 4, columns per input beat (≥1)
- DATA_WIDTH, 4, J element width
- J_SIGNED, 0, 0 = J unsigned, 1 = J two's complement
- PIPE_EN, 0, 1 inserts a register after per-column dot products
- ACCUM_WIDTH, DATA_WIDTH+$clog2(VECTOR_SIZE*VECTOR_SIZE)+1, signed accumulator/result width (≥ beat-sum width)

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort/clear
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready at a rising edge
- in_last  in  1  beat is the final beat of the transaction
- in_col_en  in  COL_PER_CC  per-column enable; disabled column contributes 0
- j_cols  in  [COL_PER_CC][VECTOR_SIZE]×DATA_WIDTH  J columns
- sigma_r  in  [VECTOR_SIZE]×2  row spin code
- sigma_c  in  [COL_PER_CC]×1  column spin
- res_valid  out  1  result held
- res_ready  in  1  result consumed when res_valid && res_ready
- res_data  out  ACCUM_WIDTH  signed transaction sum
- res_ovf  out  1  signed overflow occurred during the transaction

## Operation
- sigma_r encoding: 01 = +1, 11 = −1, 00/10 = 0. sigma_c: 1 = +1, 0 = −1.
- Per column c: dot_c = Σ_k J[c][k]·sr[k]·sc[c].
  - J is zero- or sign-extended per J_SIGNED.
  - Width is DATA_WIDTH+2+$clog2(VECTOR_SIZE), signed.
- Beat sum = Σ dot_c over enabled columns, sign-extended to ACCUM_WIDTH.
- Accumulator add is two's-complement wrap at ACCUM_WIDTH.
  - Signed overflow (both operands same sign, result sign differs) sets the sticky ovf_acc.
- FSM states and transitions:
  - ACC: in_ready = 1.
    - Accepted beat with in_last=0 → stay in ACC.
    - Accepted beat with in_last=1 → DRAIN.
  - DRAIN: in_ready = 0. Waits for the last beat to leave the pipeline.
    - On the edge the last beat's contribution lands:
      - res_data ← accumulator + beat;
      - res_ovf ← ovf_acc | this-add overflow;
      - res_valid ← 1;
      - accumulator ← 0 and ovf_acc ← 0.
    - → HOLD.
  - HOLD: in_ready = 0; res_data and res_ovf stable.
    - res_ready=1 at an edge → res_valid ← 0, → ACC.
- Non-final beats accepted back-to-back, one per cycle, in ACC.
- Beats with in_col_en = 0 are legal and add 0.
- clear = 1 at an edge, with highest priority below reset:
  - pipeline valids ← 0, accumulator ← 0, ovf_acc ← 0;
  - res_valid ← 0, res_data ← 0, res_ovf ← 0;
  - state ← ACC.
  - A beat presented in the same cycle as clear is discarded.
- rst_n low asynchronously forces the same state as clear, at any time including mid-transaction or HOLD.

## Timing
- Reset values: in_ready = 1, res_valid = 0, res_data = 0, res_ovf = 0, accumulator = 0, state = ACC.
- Inputs are registered at the accept edge E.
- A beat's contribution enters the accumulator at edge E+1+PIPE_EN.
- res_valid rises after edge E_last+1+PIPE_EN: latency 1+PIPE_EN cycles from the last-beat accept.
- DRAIN lasts 1+PIPE_EN cycles. No beat is accepted from the cycle after E_last until the cycle after the res_ready handshake.
- Minimum transaction turnaround is 3+PIPE_EN cycles (res_ready held high).
- in_ready is a registered function of the state, with no combinational path from in_valid or res_ready.
- in_valid while in_ready = 0 is ignored; the source must hold the data.

## Test plan
Bench parameters for scenarios 2–6: VECTOR_SIZE=8, COL_PER_CC=2, DATA_WIDTH=4, run with PIPE_EN=0 and PIPE_EN=1.

1. Reset/idle: hold rst_n low, then release → in_ready=1, res_valid=0, res_data=0, res_ovf=0; no output change with in_valid=0 for 20 cycles.
2. Single beat, J_SIGNED=0:
   - Stimulus: all J=3, sigma_r all 01, sigma_c={1,1}, in_col_en=11, in_last=1.
   - Required: res_valid rises 1+PIPE_EN cycles after accept, res_data=48, res_ovf=0.
   - Repeat with sigma_c={1,0} → res_data=0.
3. Multi-beat with masking:
   - Beat 1: J=5, sigma_r = four 01 and four 00, col_en=01 → +20.
   - Beat 2: J=2, sigma_r all 11, sigma_c={1,1}, col_en=11, in_last=1 → −32.
   - Required: res_data=−12; in_ready low from the cycle after beat 2 until the handshake.
4. Backpressure:
   - Stimulus: hold res_ready=0 for 5 cycles after res_valid rises, with in_valid=1 throughout.
   - Required: res_data and res_valid stable, in_ready=0, no beat accepted.
   - Then raise res_ready → res_valid=0 the next cycle, in_ready=1; the next transaction starts with accumulator 0.
5. Signed overflow, J_SIGNED=1, ACCUM_WIDTH=8:
   - Stimulus: J=7, all spins +1, two full beats, second with in_last → 112+112.
   - Required: res_data=−32, res_ovf=1.
   - Next transaction (J=−1, one column, in_last) → res_data=−8, res_ovf=0.
6. Abort:
   - clear pulsed mid-transaction after 2 beats, then a fresh 1-beat transaction of scenario 2 → res_data=48.
   - rst_n asserted during HOLD → res_valid=0 immediately, res_data=0.
